// File: rtl/cpu_gen2_pkg.sv
// Shared constants for the cpu_gen2 accumulator CPU: opcodes, FSM encoding, ALU selects, CCR bits.
package cpu_gen2_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_OPND   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_INCA = 3'd4;
    localparam logic [2:0] ALU_INCB = 3'd5;
    localparam logic [2:0] ALU_DECA = 3'd6;
    localparam logic [2:0] ALU_DECB = 3'd7;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] ccr);
        case (op)
            OP_BRA:  branch_taken = 1'b1;
            OP_BMI:  branch_taken = ccr[CCR_N];
            OP_BPL:  branch_taken = !ccr[CCR_N];
            OP_BEQ:  branch_taken = ccr[CCR_Z];
            OP_BNE:  branch_taken = !ccr[CCR_Z];
            OP_BVS:  branch_taken = ccr[CCR_V];
            OP_BVC:  branch_taken = !ccr[CCR_V];
            OP_BCS:  branch_taken = ccr[CCR_C];
            OP_BCC:  branch_taken = !ccr[CCR_C];
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_gen2_alu.sv
// Combinational ALU for cpu_gen2: add/sub/and/or and A/B increment/decrement with NZVC flags.
module cpu_gen2_alu
    import cpu_gen2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        sel_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        nzvc_o
);

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W:0]   wide;
    logic              sub;
    logic              v;
    logic              c;

    always_comb begin
        x   = a_i;
        y   = b_i;
        sub = 1'b0;
        case (sel_i)
            ALU_SUB:  sub = 1'b1;
            ALU_INCA: y = DATA_W'(1);
            ALU_INCB: begin x = b_i; y = DATA_W'(1); end
            ALU_DECA: begin y = DATA_W'(1); sub = 1'b1; end
            ALU_DECB: begin x = b_i; y = DATA_W'(1); sub = 1'b1; end
            default: ;
        endcase

        // The extra top bit is the carry for add and the borrow for subtract.
        wide     = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        result_o = wide[DATA_W-1:0];
        c        = wide[DATA_W];
        v        = sub ? ((x[DATA_W-1] != y[DATA_W-1]) && (result_o[DATA_W-1] != x[DATA_W-1]))
                       : ((x[DATA_W-1] == y[DATA_W-1]) && (result_o[DATA_W-1] != x[DATA_W-1]));

        if (sel_i == ALU_AND || sel_i == ALU_OR) begin
            result_o = (sel_i == ALU_AND) ? (a_i & b_i) : (a_i | b_i);
            v        = 1'b0;
            c        = 1'b0;
        end

        nzvc_o = {result_o[DATA_W-1], result_o == '0, v, c};
    end

endmodule

// File: rtl/cpu_gen2.sv
// Multi-cycle accumulator CPU with a req/ready memory port.
// Define WAIT_STATE_EN to honour mem_ready; otherwise every access completes in one cycle.
module cpu_gen2
    import cpu_gen2_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              write,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] from_memory,
    output logic              halted,
    output logic              illegal_op
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d;
    logic [3:0]        ccr_q, ccr_d;
    logic              illegal_q, illegal_d;

    logic [7:0]        op;
    logic              ready;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_nzvc;
    logic [ADDR_W-1:0] opnd_addr;

`ifdef WAIT_STATE_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif

    assign op        = ir_q[7:0];
    assign opnd_addr = ADDR_W'(from_memory);

    always_comb begin
        case (op)
            OP_SUB_AB: alu_sel = ALU_SUB;
            OP_AND_AB: alu_sel = ALU_AND;
            OP_OR_AB:  alu_sel = ALU_OR;
            OP_INCA:   alu_sel = ALU_INCA;
            OP_INCB:   alu_sel = ALU_INCB;
            OP_DECA:   alu_sel = ALU_DECA;
            OP_DECB:   alu_sel = ALU_DECB;
            default:   alu_sel = ALU_ADD;
        endcase
    end

    cpu_gen2_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sel_i    (alu_sel),
        .result_o (alu_res),
        .nzvc_o   (alu_nzvc)
    );

    always_comb begin
        mem_req    = (state_q == S_FETCH) || (state_q == S_OPND) || (state_q == S_MEM);
        address    = (state_q == S_MEM) ? mar_q : pc_q;
        write      = (state_q == S_MEM) && (op == OP_STA_DIR || op == OP_STB_DIR);
        to_memory  = '0;
        if (write) to_memory = (op == OP_STA_DIR) ? a_q : b_q;
        halted     = (state_q == S_HALT);
        illegal_op = illegal_q;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mar_d     = mar_q;
        a_d       = a_q;
        b_d       = b_q;
        ir_d      = ir_q;
        ccr_d     = ccr_q;
        illegal_d = illegal_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: if (ready) begin
                ir_d    = from_memory;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: case (op)
                OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB, OP_INCA, OP_INCB, OP_DECA, OP_DECB: begin
                    if (op == OP_INCB || op == OP_DECB) b_d = alu_res;
                    else a_d = alu_res;
                    ccr_d   = alu_nzvc;
                    state_d = S_FETCH;
                end
                OP_LDA_IMM, OP_LDA_DIR, OP_LDB_IMM, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR,
                OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE, OP_BVS, OP_BVC, OP_BCS, OP_BCC:
                    state_d = S_OPND;
                OP_HALT: state_d = S_HALT;
                default: begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            endcase
            S_OPND: if (ready) begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH;
                case (op)
                    OP_LDA_IMM: a_d = from_memory;
                    OP_LDB_IMM: b_d = from_memory;
                    OP_LDA_DIR, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: begin
                        mar_d   = opnd_addr;
                        state_d = S_MEM;
                    end
                    default: if (branch_taken(op, ccr_q)) pc_d = opnd_addr;
                endcase
            end
            S_MEM: if (ready) begin
                if (op == OP_LDA_DIR) a_d = from_memory;
                if (op == OP_LDB_DIR) b_d = from_memory;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_START;
            pc_q      <= RESET_VEC;
            mar_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ir_q      <= '0;
            ccr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ir_q      <= ir_d;
            ccr_q     <= ccr_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed self-checking bench for cpu_gen2 (DATA_W=8, ADDR_W=8, RESET_VEC=0).
module tb_cpu_gen2;
    import cpu_gen2_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address, to_memory, from_memory;
    logic       write, mem_req, mem_ready, halted, illegal_op, accept;

    logic [7:0] mem [0:255];
    int         wait_n = 0;
    int         stall_cnt;
    int         acc_n, wr_n;
    logic [7:0] acc_addr [0:63];
    logic [7:0] wr_addr, wr_data;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    cpu_gen2 #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .RESET_VEC (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .to_memory   (to_memory),
        .write       (write),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .from_memory (from_memory),
        .halted      (halted),
        .illegal_op  (illegal_op)
    );

    assign from_memory = mem[address];
    assign mem_ready   = (stall_cnt >= wait_n);
`ifdef WAIT_STATE_EN
    assign accept = mem_req & mem_ready;
`else
    assign accept = mem_req;
`endif

    // Memory-side observer: wait-state counter and log of completed accesses.
    always @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 0;
            acc_n     <= 0;
            wr_n      <= 0;
        end else begin
            if (mem_req) stall_cnt <= mem_ready ? 0 : stall_cnt + 1;
            if (accept) begin
                if (acc_n < 64) acc_addr[acc_n] <= address;
                acc_n <= acc_n + 1;
                if (write) begin
                    wr_n    <= wr_n + 1;
                    wr_addr <= address;
                    wr_data <= to_memory;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts rising edges after reset release until halted; -1 if the bound expires.
    task automatic run_until_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 500) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!halted) cyc = -1;
    endtask

    task automatic test_reset();
        clear_mem();
        wait_n = 0;
        do_reset();
        checks += 7;
        if (address !== 8'h00) begin errors++; $display("FAIL reset_address got %h want 00", address); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", write); end
        if (to_memory !== 8'h00) begin errors++; $display("FAIL reset_to_memory got %h want 00", to_memory); end
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
        if ({dut.a_q, dut.b_q, dut.ccr_q} !== 20'h0) begin
            errors++; $display("FAIL reset_regs got %h want 00000", {dut.a_q, dut.b_q, dut.ccr_q});
        end
    endtask

    task automatic test_add_overflow();
        int cyc;
        clear_mem();
        wait_n = 0;
        mem[0] = OP_LDA_IMM; mem[1] = 8'h7F; mem[2] = OP_LDB_IMM; mem[3] = 8'h01;
        mem[4] = OP_ADD_AB;  mem[5] = OP_HALT;
        do_reset();
        run_until_halt(cyc);
        // START 1 + LDA_IMM 3 + LDB_IMM 3 + ADD 2 + HALT fetch/decode 2
        checks += 4;
        if (cyc !== 11) begin errors++; $display("FAIL add_cycles got %0d want 11", cyc); end
        if (dut.a_q !== 8'h80) begin errors++; $display("FAIL add_a got %h want 80", dut.a_q); end
        if (dut.ccr_q !== 4'b1010) begin errors++; $display("FAIL add_nzvc got %b want 1010", dut.ccr_q); end
        if (illegal_op !== 1'b0) begin errors++; $display("FAIL add_illegal got %b want 0", illegal_op); end
    endtask

    task automatic test_load_store();
        int cyc;
        clear_mem();
        wait_n = 0;
        mem[0] = OP_LDA_DIR; mem[1] = 8'h40; mem[2] = OP_STA_DIR; mem[3] = 8'h41;
        mem[4] = OP_HALT; mem[8'h40] = 8'h05;
        do_reset();
        run_until_halt(cyc);
        checks += 5;
        if (cyc !== 11) begin errors++; $display("FAIL ldst_cycles got %0d want 11", cyc); end
        if (dut.a_q !== 8'h05) begin errors++; $display("FAIL ldst_a got %h want 05", dut.a_q); end
        if (wr_n !== 1) begin errors++; $display("FAIL ldst_write_count got %0d want 1", wr_n); end
        if (wr_addr !== 8'h41) begin errors++; $display("FAIL ldst_write_addr got %h want 41", wr_addr); end
        if (wr_data !== 8'h05) begin errors++; $display("FAIL ldst_write_data got %h want 05", wr_data); end
    endtask

    task automatic test_wait_states();
        int         cyc;
        int         exp_cyc;
        logic       held;
        logic [16:0] saved;
        clear_mem();
        wait_n = 3;
        mem[0] = OP_LDA_DIR; mem[1] = 8'h40; mem[2] = OP_STA_DIR; mem[3] = 8'h41;
        mem[4] = OP_HALT; mem[8'h40] = 8'h05;
        do_reset();
        cyc   = 0;
        held  = 1'b0;
        saved = '0;
        while (!halted && cyc < 500) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
`ifdef WAIT_STATE_EN
            if (held) begin
                checks++;
                if ({address, write, to_memory} !== saved) begin
                    errors++;
                    $display("FAIL wait_stable got %h want %h", {address, write, to_memory}, saved);
                end
            end
`endif
            held  = mem_req && !mem_ready;
            saved = {address, write, to_memory};
        end
`ifdef WAIT_STATE_EN
        exp_cyc = 32;  // 11 plus 3 stall cycles on each of 7 accesses
`else
        exp_cyc = 11;
`endif
        checks += 4;
        if (cyc !== exp_cyc) begin errors++; $display("FAIL wait_cycles got %0d want %0d", cyc, exp_cyc); end
        if (dut.a_q !== 8'h05) begin errors++; $display("FAIL wait_a got %h want 05", dut.a_q); end
        if (wr_n !== 1) begin errors++; $display("FAIL wait_write_count got %0d want 1", wr_n); end
        if ({wr_addr, wr_data} !== 16'h4105) begin
            errors++; $display("FAIL wait_write got %h want 4105", {wr_addr, wr_data});
        end
        wait_n = 0;
    endtask

    task automatic test_sub_branch(input logic [7:0] br_op, input logic [7:0] exp_pc);
        int cyc;
        clear_mem();
        wait_n = 0;
        mem[0] = OP_LDA_IMM; mem[1] = 8'h00; mem[2] = OP_LDB_IMM; mem[3] = 8'h01;
        mem[4] = OP_SUB_AB;  mem[5] = br_op; mem[6] = 8'h30; mem[7] = OP_HALT;
        mem[8'h30] = OP_HALT;
        do_reset();
        run_until_halt(cyc);
        checks += 3;
        if (dut.a_q !== 8'hFF) begin errors++; $display("FAIL sub_a op %h got %h want FF", br_op, dut.a_q); end
        if (dut.ccr_q !== 4'b1001) begin
            errors++; $display("FAIL sub_nzvc op %h got %b want 1001", br_op, dut.ccr_q);
        end
        if (dut.pc_q !== exp_pc) begin
            errors++; $display("FAIL branch_pc op %h got %h want %h", br_op, dut.pc_q, exp_pc);
        end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        clear_mem();
        wait_n = 0;
        mem[8'h00] = OP_BRA;  mem[8'h01] = 8'hFE;
        mem[8'hFE] = OP_INCA; mem[8'hFF] = OP_BRA;
        mem[8'h20] = OP_HALT;  // BRA at FF takes its operand from 00, i.e. 20
        do_reset();
        run_until_halt(cyc);
        checks += 5;
        if (acc_n !== 6) begin errors++; $display("FAIL wrap_access_count got %0d want 6", acc_n); end
        if (acc_addr[4] !== 8'h00) begin errors++; $display("FAIL wrap_operand_addr got %h want 00", acc_addr[4]); end
        if (acc_addr[5] !== 8'h20) begin errors++; $display("FAIL wrap_target_addr got %h want 20", acc_addr[5]); end
        if (dut.a_q !== 8'h01) begin errors++; $display("FAIL wrap_a got %h want 01", dut.a_q); end
        if (dut.pc_q !== 8'h21) begin errors++; $display("FAIL wrap_pc got %h want 21", dut.pc_q); end
    endtask

    task automatic test_illegal();
        int cyc;
        clear_mem();
        wait_n = 0;
        do_reset();
        run_until_halt(cyc);
        checks += 3;
        if (cyc !== 3) begin errors++; $display("FAIL illegal_cycles got %0d want 3", cyc); end
        if (illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", illegal_op); end
        if (halted !== 1'b1) begin errors++; $display("FAIL illegal_halted got %b want 1", halted); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({mem_req, halted, illegal_op} !== 3'b011) begin
                errors++;
                $display("FAIL illegal_absorb cycle %0d got %b want 011", i, {mem_req, halted, illegal_op});
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        clear_mem();
        wait_n = 3;
        mem[0] = OP_STA_DIR; mem[1] = 8'h50;
        do_reset();
        cyc = 0;
        while (write !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (write !== 1'b1) begin
            errors++; $display("FAIL midwrite_reach got write=%b want 1", write);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (write !== 1'b0) begin errors++; $display("FAIL midwrite_write got %b want 0", write); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL midwrite_req got %b want 0", mem_req); end
        if (dut.pc_q !== 8'h00) begin errors++; $display("FAIL midwrite_pc got %h want 00", dut.pc_q); end
        if (address !== 8'h00) begin errors++; $display("FAIL midwrite_addr got %h want 00", address); end
        reset  = 1'b0;
        wait_n = 0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_load_store();
        test_wait_states();
        test_sub_branch(OP_BCS, 8'h31);
        test_sub_branch(OP_BCC, 8'h08);
        test_pc_wrap();
        test_illegal();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
